// File: rtl/uart_tx_gen_if.sv
// Payload handshake between a producer (master) and the UART transmitter (slave).
interface uart_tx_gen_if #(
  parameter int DATA_W = 9
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_gen.sv
// Configurable UART transmitter: start, 5..DATA_W data bits, optional parity,
// 1..STOP_MAX stop bits, break generation; one bit per ce_tx strobe.
module uart_tx_gen #(
  parameter int DATA_W   = 9,
  parameter int STOP_MAX = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce_tx,
  uart_tx_gen_if.slave tx_bus,
  output logic         uart_tx,
  output logic         is_transmitting,
  output logic         tx_done,
  input  logic [3:0]   cfg_data_bits,
  input  logic [1:0]   cfg_stop_bit,
  input  logic [2:0]   cfg_parity_type,
  input  logic         cfg_lsb_first,
  input  logic         cfg_break,
  input  logic         cfg_channel_enable
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ALIGN  = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_PARITY = 3'd4;
  localparam logic [2:0] S_STOP   = 3'd5;
  localparam logic [2:0] S_BREAK  = 3'd6;

  localparam logic [2:0] PAR_NONE  = 3'd0;
  localparam logic [2:0] PAR_ODD   = 3'd1;
  localparam logic [2:0] PAR_EVEN  = 3'd2;
  localparam logic [2:0] PAR_MARK  = 3'd3;

  logic [2:0]  state;
  logic [15:0] data_q;
  logic [3:0]  nbits_q;
  logic [1:0]  nstop_q;
  logic [2:0]  par_q;
  logic        lsb_q;
  logic [3:0]  bit_cnt;
  logic [1:0]  stop_cnt;

  logic [3:0]  bits_clamped;
  logic [1:0]  stop_clamped;
  logic [2:0]  par_clamped;
  logic [3:0]  next_cnt;
  logic [3:0]  bit_idx;
  logic        data_bit;
  logic        data_xor;
  logic        parity_bit;
  logic        accept;

  assign tx_bus.tx_ready = !rst && (state == S_IDLE) && cfg_channel_enable && !cfg_break;
  assign accept          = tx_bus.tx_valid && tx_bus.tx_ready;
  assign is_transmitting = (state != S_IDLE) && (state != S_BREAK);

  // Out-of-range configuration is folded into the legal range before latching.
  always_comb begin
    bits_clamped = cfg_data_bits;
    if (cfg_data_bits < 4'd5)
      bits_clamped = 4'd5;
    else if (cfg_data_bits > 4'(DATA_W))
      bits_clamped = 4'(DATA_W);
    stop_clamped = cfg_stop_bit;
    if (cfg_stop_bit == 2'd0)
      stop_clamped = 2'd1;
    else if (cfg_stop_bit > 2'(STOP_MAX))
      stop_clamped = 2'(STOP_MAX);
    par_clamped = (cfg_parity_type > 3'd4) ? PAR_NONE : cfg_parity_type;
  end

  assign next_cnt = (state == S_START) ? 4'd0 : bit_cnt + 4'd1;
  assign bit_idx  = lsb_q ? next_cnt : (nbits_q - 4'd1 - next_cnt);
  assign data_bit = data_q[bit_idx];

  always_comb begin
    data_xor = 1'b0;
    for (int i = 0; i < DATA_W; i++)
      if (4'(i) < nbits_q)
        data_xor = data_xor ^ data_q[i];
    case (par_q)
      PAR_ODD:  parity_bit = ~data_xor;
      PAR_EVEN: parity_bit = data_xor;
      PAR_MARK: parity_bit = 1'b1;
      default:  parity_bit = 1'b0;
    endcase
  end

  // The line register is updated on the same edge that consumes ce_tx, so
  // each bit appears one clk after its strobe and holds until the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      uart_tx  <= 1'b1;
      tx_done  <= 1'b0;
      data_q   <= '0;
      nbits_q  <= '0;
      nstop_q  <= '0;
      par_q    <= '0;
      lsb_q    <= 1'b0;
      bit_cnt  <= '0;
      stop_cnt <= '0;
    end else begin
      tx_done <= 1'b0;
      if (!cfg_channel_enable) begin
        state    <= S_IDLE;
        uart_tx  <= 1'b1;
        bit_cnt  <= '0;
        stop_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (cfg_break) begin
              state   <= S_BREAK;
              uart_tx <= 1'b0;
            end else if (accept) begin
              data_q  <= 16'(tx_bus.tx_data);
              nbits_q <= bits_clamped;
              nstop_q <= stop_clamped;
              par_q   <= par_clamped;
              lsb_q   <= cfg_lsb_first;
              state   <= S_ALIGN;
            end
          end
          S_ALIGN: begin
            if (ce_tx) begin
              state   <= S_START;
              uart_tx <= 1'b0;
            end
          end
          S_START: begin
            if (ce_tx) begin
              state   <= S_DATA;
              bit_cnt <= 4'd0;
              uart_tx <= data_bit;
            end
          end
          S_DATA: begin
            if (ce_tx) begin
              if (bit_cnt == nbits_q - 4'd1) begin
                if (par_q == PAR_NONE) begin
                  state    <= S_STOP;
                  stop_cnt <= 2'd0;
                  uart_tx  <= 1'b1;
                end else begin
                  state   <= S_PARITY;
                  uart_tx <= parity_bit;
                end
              end else begin
                bit_cnt <= next_cnt;
                uart_tx <= data_bit;
              end
            end
          end
          S_PARITY: begin
            if (ce_tx) begin
              state    <= S_STOP;
              stop_cnt <= 2'd0;
              uart_tx  <= 1'b1;
            end
          end
          S_STOP: begin
            if (ce_tx) begin
              if (stop_cnt == nstop_q - 2'd1) begin
                state   <= S_IDLE;
                tx_done <= 1'b1;
              end else begin
                stop_cnt <= stop_cnt + 2'd1;
              end
            end
          end
          S_BREAK: begin
            if (ce_tx && !cfg_break) begin
              state   <= S_IDLE;
              uart_tx <= 1'b1;
            end
          end
          default: begin
            state   <= S_IDLE;
            uart_tx <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_gen.sv
// Self-checking bench for uart_tx_gen: directed and random frames compared
// against a bit-list model of the frame format.
module tb_uart_tx_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce_tx;
  logic       uart_tx;
  logic       is_transmitting;
  logic       tx_done;
  logic [3:0] cfg_data_bits;
  logic [1:0] cfg_stop_bit;
  logic [2:0] cfg_parity_type;
  logic       cfg_lsb_first;
  logic       cfg_break;
  logic       cfg_channel_enable;

  uart_tx_gen_if #(.DATA_W(9)) bus ();

  uart_tx_gen #(.DATA_W(9), .STOP_MAX(2)) dut (
    .clk                (clk),
    .rst                (rst),
    .ce_tx              (ce_tx),
    .tx_bus             (bus),
    .uart_tx            (uart_tx),
    .is_transmitting    (is_transmitting),
    .tx_done            (tx_done),
    .cfg_data_bits      (cfg_data_bits),
    .cfg_stop_bit       (cfg_stop_bit),
    .cfg_parity_type    (cfg_parity_type),
    .cfg_lsb_first      (cfg_lsb_first),
    .cfg_break          (cfg_break),
    .cfg_channel_enable (cfg_channel_enable)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int period = 16;
  int phase = 0;
  bit last_ce = 1'b0;
  bit exp_bits[$];

  // One clock: ce_tx is a periodic strobe; outputs are sampled 1 ns after the edge.
  task automatic tick();
    ce_tx = (phase == period - 1);
    @(posedge clk);
    #1;
    last_ce = ce_tx;
    phase = (phase + 1) % period;
  endtask

  task automatic set_period(input int p);
    period = p;
    phase = 0;
  endtask

  // Expected line levels for one frame, one entry per bit period.
  task automatic build_expected(input logic [8:0] d, input int nb, input int st,
                                input int par, input bit lsb);
    int n, s, p, ones;
    n = (nb < 5) ? 5 : ((nb > 9) ? 9 : nb);
    s = (st < 1) ? 1 : ((st > 2) ? 2 : st);
    p = (par > 4) ? 0 : par;
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int i = 0; i < n; i++)
      exp_bits.push_back(lsb ? d[i] : d[n - 1 - i]);
    ones = 0;
    for (int i = 0; i < n; i++)
      ones += int'(d[i]);
    case (p)
      1: exp_bits.push_back((ones % 2) == 0);
      2: exp_bits.push_back((ones % 2) == 1);
      3: exp_bits.push_back(1'b1);
      4: exp_bits.push_back(1'b0);
      default: ;
    endcase
    repeat (s) exp_bits.push_back(1'b1);
  endtask

  task automatic send_frame(input logic [8:0] d, input int nb, input int st, input int par,
                            input bit lsb, input bit sync_ce, input bit raise_break,
                            input string name);
    int n, ce_seen, ticks, hold_bad, busy_bad, done_cnt;
    bit got[$];
    logic [15:0] gv, ev;
    logic cur, line_end, busy_end, ready_end, done_end;
    bit finished;
    build_expected(d, nb, st, par, lsb);
    n = exp_bits.size();
    ticks = 0;
    while (bus.tx_ready !== 1'b1 && ticks < 200) begin
      tick();
      ticks++;
    end
    if (sync_ce)
      while (phase != period - 1) tick();
    total++;
    if (bus.tx_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL %s.ready got=%b want=1", name, bus.tx_ready);
    end
    bus.tx_data     = d;
    cfg_data_bits   = 4'(nb);
    cfg_stop_bit    = 2'(st);
    cfg_parity_type = 3'(par);
    cfg_lsb_first   = lsb;
    bus.tx_valid    = 1'b1;
    tick();
    bus.tx_valid    = 1'b0;
    bus.tx_data     = 9'($urandom);
    cfg_data_bits   = 4'($urandom);
    cfg_stop_bit    = 2'($urandom);
    cfg_parity_type = 3'($urandom);
    cfg_lsb_first   = 1'($urandom);
    if (raise_break) cfg_break = 1'b1;
    cur = 1'b1;
    ce_seen = 0; hold_bad = 0; busy_bad = 0; done_cnt = 0; finished = 1'b0;
    line_end = 1'b0; busy_end = 1'b1; ready_end = 1'b0; done_end = 1'b0;
    for (int t = 0; t < (n + 2) * period + 4 && !finished; t++) begin
      tick();
      if (last_ce) begin
        ce_seen++;
        if (ce_seen <= n) begin
          got.push_back(uart_tx);
          cur = uart_tx;
          if (tx_done !== 1'b0) done_cnt++;
          if (is_transmitting !== 1'b1) busy_bad++;
        end else begin
          finished  = 1'b1;
          line_end  = uart_tx;
          busy_end  = is_transmitting;
          ready_end = bus.tx_ready;
          done_end  = tx_done;
        end
      end else begin
        if (uart_tx !== cur) hold_bad++;
        if (tx_done !== 1'b0) done_cnt++;
        if (is_transmitting !== 1'b1) busy_bad++;
      end
    end
    total++;
    if (!finished) begin
      bad++;
      $display("[TB] FAIL %s.timeout got=%0d_strobes want=%0d_strobes", name, ce_seen, n + 1);
    end
    gv = '0; ev = '0;
    foreach (got[i]) if (i < 16) gv[i] = got[i];
    foreach (exp_bits[i]) if (i < 16) ev[i] = exp_bits[i];
    total++;
    if (got.size() != n || gv !== ev) begin
      bad++;
      $display("[TB] FAIL %s.bits got=%0d'b%b want=%0d'b%b (bit0 rightmost)",
               name, got.size(), gv, n, ev);
    end
    total++;
    if (hold_bad != 0) begin
      bad++;
      $display("[TB] FAIL %s.hold got=%0d_changes want=0", name, hold_bad);
    end
    total++;
    if (busy_bad != 0 || busy_end !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s.busy got=%0d_gaps,end=%b want=0,end=0", name, busy_bad, busy_end);
    end
    total++;
    if (done_cnt != 0 || done_end !== 1'b1) begin
      bad++;
      $display("[TB] FAIL %s.done got=early%0d,end=%b want=early0,end=1", name, done_cnt, done_end);
    end
    total++;
    if (line_end !== 1'b1 || ready_end !== !cfg_break) begin
      bad++;
      $display("[TB] FAIL %s.end got=line%b,ready%b want=line1,ready%b",
               name, line_end, ready_end, !cfg_break);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.tx_valid = 1'b1;
    tick();
    tick();
    total++;
    if (uart_tx !== 1'b1 || is_transmitting !== 1'b0 || tx_done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset.outputs got=%b%b%b want=100", uart_tx, is_transmitting, tx_done);
    end
    total++;
    if (bus.tx_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset.ready got=%b want=0", bus.tx_ready);
    end
    rst = 1'b0;
    bus.tx_valid = 1'b0;
    #1;
    total++;
    if (bus.tx_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset.ready_after got=%b want=1", bus.tx_ready);
    end
  endtask

  task automatic test_idle();
    int odd;
    set_period(4);
    odd = 0;
    repeat (3 * period) begin
      tick();
      if (uart_tx !== 1'b1 || is_transmitting !== 1'b0 || tx_done !== 1'b0) odd++;
    end
    total++;
    if (odd != 0) begin
      bad++;
      $display("[TB] FAIL idle.ce_ignored got=%0d_bad_cycles want=0", odd);
    end
    cfg_channel_enable = 1'b0;
    #1;
    total++;
    if (bus.tx_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL idle.disabled_ready got=%b want=0", bus.tx_ready);
    end
    cfg_channel_enable = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    set_period(16);
    send_frame(9'h055, 8, 1, 0, 1'b1, 1'b0, 1'b0, "8n1");
    set_period(8);
    send_frame(9'h1A3, 7, 2, 2, 1'b0, 1'b0, 1'b0, "7e2_msb");
    set_period(5);
    send_frame(9'h000, 8, 1, 1, 1'b1, 1'b0, 1'b0, "odd_zero");
    send_frame(9'h0B6, 6, 1, 3, 1'b1, 1'b0, 1'b0, "mark_b2b");
    send_frame(9'h1FF, 9, 2, 4, 1'b0, 1'b0, 1'b0, "space_b2b");
    set_period(6);
    send_frame(9'h0E1, 8, 1, 2, 1'b1, 1'b1, 1'b0, "ce_on_accept");
    set_period(4);
    send_frame(9'h15A, 12, 3, 7, 1'b1, 1'b0, 1'b0, "clamp_hi");
    send_frame(9'h0F0, 2, 0, 1, 1'b0, 1'b0, 1'b0, "clamp_lo");
  endtask

  task automatic test_abort(input bit use_rst, input string name);
    int ce_seen, ticks, odd;
    set_period(4);
    cfg_break = 1'b0;
    ticks = 0;
    while (bus.tx_ready !== 1'b1 && ticks < 50) begin
      tick();
      ticks++;
    end
    bus.tx_data = 9'h0A5;
    cfg_data_bits = 4'd8;
    cfg_stop_bit = 2'd1;
    cfg_parity_type = 3'd0;
    cfg_lsb_first = 1'b1;
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
    ce_seen = 0;
    ticks = 0;
    while (ce_seen < 5 && ticks < 40) begin
      tick();
      ticks++;
      if (last_ce) ce_seen++;
    end
    tick();
    total++;
    if (uart_tx !== 1'b0 || is_transmitting !== 1'b1) begin
      bad++;
      $display("[TB] FAIL %s.bit3 got=line%b,busy%b want=line0,busy1", name, uart_tx, is_transmitting);
    end
    if (use_rst) rst = 1'b1;
    else cfg_channel_enable = 1'b0;
    tick();
    total++;
    if (uart_tx !== 1'b1 || is_transmitting !== 1'b0 || tx_done !== 1'b0 || bus.tx_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s.abort got=line%b,busy%b,done%b,ready%b want=line1,busy0,done0,ready0",
               name, uart_tx, is_transmitting, tx_done, bus.tx_ready);
    end
    rst = 1'b0;
    cfg_channel_enable = 1'b1;
    odd = 0;
    repeat (3 * period) begin
      tick();
      if (tx_done !== 1'b0 || uart_tx !== 1'b1 || is_transmitting !== 1'b0) odd++;
    end
    total++;
    if (odd != 0) begin
      bad++;
      $display("[TB] FAIL %s.after got=%0d_bad_cycles want=0", name, odd);
    end
    total++;
    if (bus.tx_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL %s.ready got=%b want=1", name, bus.tx_ready);
    end
  endtask

  task automatic test_break_midframe();
    int odd, ticks;
    bit exited;
    set_period(6);
    send_frame(9'h0C3, 8, 1, 2, 1'b1, 1'b0, 1'b1, "brk_frame");
    tick();
    total++;
    if (uart_tx !== 1'b0 || bus.tx_ready !== 1'b0 || is_transmitting !== 1'b0) begin
      bad++;
      $display("[TB] FAIL brk.enter got=line%b,ready%b,busy%b want=line0,ready0,busy0",
               uart_tx, bus.tx_ready, is_transmitting);
    end
    odd = 0;
    repeat (2 * period) begin
      tick();
      if (uart_tx !== 1'b0 || bus.tx_ready !== 1'b0) odd++;
    end
    total++;
    if (odd != 0) begin
      bad++;
      $display("[TB] FAIL brk.hold got=%0d_bad_cycles want=0", odd);
    end
    cfg_break = 1'b0;
    odd = 0;
    ticks = 0;
    exited = 1'b0;
    while (!exited && ticks < 2 * period) begin
      tick();
      ticks++;
      if (last_ce) exited = 1'b1;
      else if (uart_tx !== 1'b0) odd++;
    end
    total++;
    if (!exited || odd != 0 || uart_tx !== 1'b1) begin
      bad++;
      $display("[TB] FAIL brk.exit got=strobe%b,early%0d,line%b want=strobe1,early0,line1",
               exited, odd, uart_tx);
    end
    total++;
    if (bus.tx_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL brk.ready got=%b want=1", bus.tx_ready);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 16; k++) begin
      set_period($urandom_range(3, 10));
      send_frame(9'($urandom), $urandom_range(0, 15), $urandom_range(0, 3),
                 $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0), 1'b0, "rand");
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    ce_tx = 1'b0;
    bus.tx_data = '0;
    bus.tx_valid = 1'b0;
    cfg_data_bits = 4'd8;
    cfg_stop_bit = 2'd1;
    cfg_parity_type = 3'd0;
    cfg_lsb_first = 1'b1;
    cfg_break = 1'b0;
    cfg_channel_enable = 1'b1;
    $display("[TB] start");
    test_reset();
    test_idle();
    test_directed();
    test_abort(1'b0, "disable");
    test_abort(1'b1, "rst");
    test_break_midframe();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
